// File: rtl/shift_history_display_if.sv
// Bus between the board-facing test/driver side and the history display stage.
//   din      : 8-bit shifter result offered for capture
//   cap_btn  : raw capture button (active-high, bouncy)
//   clr_btn  : raw clear button (active-high, bouncy)
//   count    : number of valid history entries, 0..4
//   full     : high when count == 4
//   seg0..7  : active-low seven-segment digit patterns (bit7 = dp)
interface shift_history_display_if;
  logic [7:0] din;
  logic       cap_btn;
  logic       clr_btn;
  logic [2:0] count;
  logic       full;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic [7:0] seg4;
  logic [7:0] seg5;
  logic [7:0] seg6;
  logic [7:0] seg7;

  modport master (
    output din, cap_btn, clr_btn,
    input  count, full, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );

  modport slave (
    input  din, cap_btn, clr_btn,
    output count, full, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );
endinterface

// File: rtl/shift_history_display.sv
// Debounces capture/clear buttons, keeps a 4-deep history of captured shifter
// results and shows them as hex on eight seven-segment digits (newest on
// seg1:seg0).
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : shift_history_display_if.slave (din, buttons in; count, full, seg0..7 out)
module shift_history_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst,
  shift_history_display_if.slave  bus
);

  localparam int unsigned CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DEPTH = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Active-low hex patterns, dp off; index = nibble value.
  localparam logic [15:0][7:0] HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Bit 0 = capture button, bit 1 = clear button.
  logic [1:0]         btn_raw;
  logic [1:0]         s1;
  logic [1:0]         s2;
  logic [1:0]         db;
  logic [1:0]         db_d;
  logic [1:0][CW-1:0] cnt;
  logic [1:0]         press_c;

  logic [DEPTH-1:0][7:0] ent;
  logic [2:0]            count;
  logic                  full;
  logic [7:0][7:0]       seg_n;
  logic [7:0][7:0]       seg_q;

  assign btn_raw = {bus.clr_btn, bus.cap_btn};

  // Synchronizers and per-button debounce counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      cnt  <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_d <= db;
      for (int b = 0; b < 2; b++) begin
        if (s2[b] == db[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          db[b]  <= s2[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  // One-cycle press on debounced rising edge only.
  assign press_c = db & ~db_d;

  // History shift register; clear dominates a simultaneous capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent   <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (press_c[1]) begin
      ent   <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (press_c[0]) begin
      ent <= {ent[DEPTH-2:0], bus.din};
      if (count != 3'(DEPTH)) begin
        count <= count + 3'd1;
      end
      full <= (count >= 3'(DEPTH - 1));
    end
  end

  // Digit patterns from the current history; entries beyond count are blank.
  always_comb begin
    seg_n = {8{8'hFF}};
    for (int k = 0; k < DEPTH; k++) begin
      if (3'(k) < count) begin
        seg_n[2*k]   = HEX[ent[k][3:0]];
        seg_n[2*k+1] = HEX[ent[k][7:4]];
      end
    end
    seg_n[7][7] = ~full;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q <= {8{8'hFF}};
    end else begin
      seg_q <= seg_n;
    end
  end

  assign bus.count = count;
  assign bus.full  = full;
  assign bus.seg0  = seg_q[0];
  assign bus.seg1  = seg_q[1];
  assign bus.seg2  = seg_q[2];
  assign bus.seg3  = seg_q[3];
  assign bus.seg4  = seg_q[4];
  assign bus.seg5  = seg_q[5];
  assign bus.seg6  = seg_q[6];
  assign bus.seg7  = seg_q[7];

endmodule

// File: tb/tb_shift_history_display.sv
// Self-checking bench for shift_history_display with DEBOUNCE_CYCLES = 4.
// Reference model: a queue of captured bytes (newest first) plus the hex table.
module tb_shift_history_display;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shift_history_display_if ifc ();

  shift_history_display #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] hist [$];
  logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic [7:0] segs [8];
  assign segs[0] = ifc.seg0;
  assign segs[1] = ifc.seg1;
  assign segs[2] = ifc.seg2;
  assign segs[3] = ifc.seg3;
  assign segs[4] = ifc.seg4;
  assign segs[5] = ifc.seg5;
  assign segs[6] = ifc.seg6;
  assign segs[7] = ifc.seg7;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    logic [7:0] v;
    logic [7:0] e;
    int k;
    k = d / 2;
    v = 8'hFF;
    if (k < hist.size()) begin
      e = hist[k];
      v = (d % 2 == 0) ? hex_tab[e[3:0]] : hex_tab[e[7:4]];
    end
    if (d == 7 && hist.size() == 4) v[7] = 1'b0;
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " count"}, 8'(ifc.count), 8'(hist.size()));
    chk({tag, " full"}, 8'(ifc.full), 8'(hist.size() == 4));
    for (int d = 0; d < 8; d++)
      chk($sformatf("%s seg%0d", tag, d), segs[d], exp_seg(d));
  endtask

  task automatic tick_rand();
    ifc.din = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Buttons already set before the first edge (edge T). Capture/clear lands on
  // edge T+2+D using din driven for that edge; segments follow one edge later.
  task automatic event_wait(input int kind, input bit fixed, input logic [7:0] val,
                            input string tag);
    int old;
    logic [7:0] dv;
    old = hist.size();
    dv  = '0;
    for (int i = 0; i < D + 3; i++) begin
      dv = (fixed && i == D + 2) ? val : 8'($urandom);
      ifc.din = dv;
      @(posedge clk);
      #1;
      if (i == D + 1) chk({tag, " pre-event count"}, 8'(ifc.count), 8'(old));
    end
    if (kind == 0) begin
      hist.push_front(dv);
      if (hist.size() > 4) hist.delete(4);
    end else begin
      hist.delete();
    end
    chk({tag, " event count"}, 8'(ifc.count), 8'(hist.size()));
    tick_rand();
    check_all(tag);
  endtask

  // kind: 0 capture, 1 clear, 2 both together.
  task automatic press(input int kind, input bit fixed, input logic [7:0] val,
                       input string tag);
    ifc.cap_btn = (kind != 1);
    ifc.clr_btn = (kind != 0);
    event_wait(kind, fixed, val, tag);
  endtask

  // Hold a while (no repeat), then release and let the release debounce.
  task automatic hold_release(input string tag);
    for (int i = 0; i < 6; i++) tick_rand();
    check_all({tag, " held"});
    ifc.cap_btn = 1'b0;
    ifc.clr_btn = 1'b0;
    for (int i = 0; i < D + 4; i++) tick_rand();
    check_all({tag, " released"});
  endtask

  initial begin
    ifc.din     = '0;
    ifc.cap_btn = 1'b0;
    ifc.clr_btn = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick_rand();
    check_all("reset");
    rst = 1'b1;
    tick_rand();
    check_all("post-reset idle");

    // 1: clean capture of 3A
    press(0, 1'b1, 8'h3A, "cap3A");
    chk("cap3A seg0 literal", segs[0], 8'h88);
    chk("cap3A seg1 literal", segs[1], 8'hB0);
    hold_release("cap3A");

    // 2: bouncy press yields one capture
    foreach (hex_tab[i]) if (i < 4) begin
      ifc.cap_btn = (i % 2 == 0);
      tick_rand();
    end
    press(0, 1'b0, 8'h00, "bouncy");
    hold_release("bouncy");

    // 3: five captures 01..05
    for (int n = 1; n <= 5; n++) begin
      press(0, 1'b1, 8'(n), $sformatf("seq%0d", n));
      hold_release($sformatf("seq%0d", n));
    end
    chk("full seg7 literal", segs[7], 8'h40);
    chk("full seg0 literal", segs[0], 8'h92);

    // 4: clear, refill to 3, clear at count 3, capture FF
    press(1, 1'b0, 8'h00, "clr4");
    hold_release("clr4");
    for (int n = 0; n < 3; n++) begin
      press(0, 1'b0, 8'h00, "fill");
      hold_release("fill");
    end
    press(1, 1'b0, 8'h00, "clr3");
    hold_release("clr3");
    press(0, 1'b1, 8'hFF, "capFF");
    chk("capFF seg0 literal", segs[0], 8'h8E);
    chk("capFF seg1 literal", segs[1], 8'h8E);
    hold_release("capFF");

    // 5: capture and clear together
    press(2, 1'b0, 8'h00, "both");
    hold_release("both");

    // 6: reset mid-debounce with button held
    press(0, 1'b0, 8'h00, "pre6");
    hold_release("pre6");
    ifc.cap_btn = 1'b1;
    tick_rand();
    tick_rand();
    rst = 1'b0;
    tick_rand();
    tick_rand();
    hist.delete();
    check_all("mid reset");
    rst = 1'b1;
    event_wait(0, 1'b0, 8'h00, "held-through-reset");
    hold_release("held-through-reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_history_display.md
# shift_history_display

Downstream display stage for the barrel-shifter result bus. It debounces a capture button and a clear button. On each capture press it records the current 8-bit shifter result into a 4-deep history. It then drives the eight seven-segment digits with the last four results in hexadecimal, newest on seg1:seg0. Sits between the shifter's combinational `q` output and the board's seg0–seg7.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples required to accept a button level change; legal range 2..2^20. Bench uses 4.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- din  input  8  shifter result to capture
- cap_btn  input  1  raw capture button, active-high, asynchronous, bouncy
- clr_btn  input  1  raw clear button, active-high, asynchronous, bouncy
- count  output  3  number of valid history entries, 0..4
- full  output  1  1 when count == 4
- seg0..seg7  output  8 each  digit segments, active-low; bit0=a … bit6=g, bit7=dp

## Operation
- **Synchronizer:** each button passes through its own 2-flop synchronizer (s1, s2).
- **Debouncer** (per button): holds state `db` and counter `cnt`.
  - If s2 == db: cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: db <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A `db` 0→1 transition produces a one-cycle `press` pulse. Releases produce no event.
- **History:** four registers e0 (newest) to e3, plus `count`.
  - Capture press (clear not pressing in the same cycle):
    - e3<=e2, e2<=e1, e1<=e0, e0<=din, where din is sampled in the pulse cycle.
    - count <= min(count+1, 4).
    - At count == 4 the oldest entry (e3) is discarded.
  - Clear press: e0..e3 <= 0, count <= 0.
  - Clear and capture pulses in the same cycle: clear wins; capture is dropped.
- **Display** (registered):
  - seg(2k) shows the low nibble of ek; seg(2k+1) shows the high nibble of ek, for k = 0..3.
  - Digits of entries with index ≥ count show blank (8'hFF).
  - Hex patterns, dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - seg7 bit7 (dp) = ~full. All other dp bits = 1.
- `count` and `full` come directly from registers. `full` is updated in the same cycle as `count`.

## Timing
- **Reset (rst=0 at an edge):**
  - s1, s2, db, cnt, e0..e3, count all 0.
  - full = 0; seg0..seg7 = 8'hFF.
  - Any debounce in progress is discarded.
- **Press latency:** raw level changes before edge T and stays stable.
  - s2 reflects it after edge T+1.
  - db changes after edge T+1+DEBOUNCE_CYCLES; the press pulse is high for the following cycle.
  - e0/count update at the next edge: T+2+DEBOUNCE_CYCLES.
  - Segments update one edge later: T+3+DEBOUNCE_CYCLES.
- **Bounce:** any synchronized sample equal to db restarts cnt at 0. A pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- **Held button:** a button held through reset release is seen as 0→1 after debounce and produces exactly one press.
- **Repeat presses:** holding a button produces one press only. A new press requires a debounced release first.
- **din:** din may change every cycle; only the value in the pulse cycle is stored.

## Test plan
1. Reset with DEBOUNCE_CYCLES=4 → all seg = FF, count=0, full=0. Clean cap_btn press with din=8'h3A → after 7 cycles, seg0=88, seg1=B0, seg2..seg7=FF, count=1.
2. Bouncy press: toggle cap_btn 1,0,1,0 each cycle, then hold high → exactly one capture, count increments by 1 only.
3. Five captures of 01,02,03,04,05 → e0..e3 = 05,04,03,02; count=4; full=1; seg7=1xC0 with dp lit (8'h40); seg0=92.
4. Clear press with count=3 → all seg = FF, count=0; a following capture of 8'hFF → seg0=seg1=8E.
5. Capture and clear pressed in the same cycle → count=0 and no entry stored.
6. Reset asserted mid-debounce with cap_btn still high, then released → outputs at reset values; exactly one capture occurs DEBOUNCE_CYCLES+3 cycles after release.
